// File: rtl/uart_tx_cfg_if.sv
// FIFO pull port between the TX FIFO (slave) and the UART transmitter (master).
// The transmitter samples `in` on the same edge that it raises `get`.
interface uart_tx_cfg_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic             get;
  logic             empty;

  modport master (
    output get,
    input  in,
    input  empty
  );

  modport slave (
    input  get,
    output in,
    output empty
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: pulls words from a FIFO and serialises them LSB first with
// run-time baud divisor, parity mode, stop-bit count, CTS gating and line break.
module uart_tx_cfg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIV_BITS = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  uart_tx_cfg_if.master       fifo,
  input  logic                cts_i,
  input  logic [DIV_BITS-1:0] div_i,
  input  logic [1:0]          parity_i,
  input  logic                stop2_i,
  input  logic                brk_i,
  output logic                tx_o,
  output logic                busy_o
);

  if ((WIDTH < 5) || (WIDTH > 9)) begin : g_width_check
    $error("uart_tx_cfg: WIDTH must be within 5..9");
  end

  localparam logic [3:0]          LastBit = 4'(WIDTH - 1);
  localparam logic [DIV_BITS-1:0] CntOne  = DIV_BITS'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop,
    StBreak,
    StMark
  } state_e;

  state_e              state_q;
  logic [DIV_BITS-1:0] div_q;
  logic [DIV_BITS-1:0] cnt_q;
  logic [WIDTH-1:0]    shift_q;
  logic [3:0]          bit_q;
  logic                par_en_q;
  logic                par_bit_q;
  logic                stop2_q;
  logic                tx_q;
  logic                cts_meta_q;
  logic                cts_s_q;
  logic                get;
  logic                bit_end;

  // Parity bit for a frame; mark mode (and the unused 00 case) yields 1.
  function automatic logic parity_bit(input logic [1:0] mode, input logic [WIDTH-1:0] d);
    logic p;
    case (mode)
      2'b01:   p = ^d;
      2'b10:   p = ~^d;
      default: p = 1'b1;
    endcase
    return p;
  endfunction

  // Two-flop synchroniser for the asynchronous active-low clear-to-send pin.
  always_ff @(posedge clock_i) begin
    cts_meta_q <= cts_i;
    cts_s_q    <= cts_meta_q;
  end

  // Pop only from idle; break request wins, and reset suppresses the strobe outright.
  assign get      = ~reset_i & (state_q == StIdle) & ~brk_i & ~cts_s_q & ~fifo.empty;
  assign fifo.get = get;

  // The baud counter counts down from div; zero marks the last clock of the current bit.
  assign bit_end = (cnt_q == '0);

  // Frame sequencer: every field is registered, config is frozen at the pop edge.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (brk_i) begin
            state_q <= StBreak;
            tx_q    <= 1'b0;
            div_q   <= div_i;
            cnt_q   <= div_i;
          end else if (get) begin
            state_q   <= StStart;
            tx_q      <= 1'b0;
            div_q     <= div_i;
            cnt_q     <= div_i;
            shift_q   <= fifo.in;
            par_en_q  <= (parity_i != 2'b00);
            par_bit_q <= parity_bit(parity_i, fifo.in);
            stop2_q   <= stop2_i;
            bit_q     <= '0;
          end
        end

        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            cnt_q   <= div_q;
            tx_q    <= shift_q[0];
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end

        StData: begin
          if (bit_end) begin
            cnt_q <= div_q;
            if (bit_q == LastBit) begin
              bit_q <= '0;
              if (par_en_q) begin
                state_q <= StPar;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b1;
              end
            end else begin
              // shift_q[0] is the bit now on the line, so [1] is the next one out.
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end

        StPar: begin
          if (bit_end) begin
            state_q <= StStop;
            cnt_q   <= div_q;
            tx_q    <= 1'b1;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end

        StStop: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            if (stop2_q && (bit_q == 4'd0)) begin
              bit_q <= 4'd1;
              cnt_q <= div_q;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end

        StBreak: begin
          // Counter parks at zero once the minimum break period is served.
          if (!bit_end) begin
            cnt_q <= cnt_q - CntOne;
            tx_q  <= 1'b0;
          end else if (!brk_i) begin
            state_q <= StMark;
            cnt_q   <= div_q;
            tx_q    <= 1'b1;
          end else begin
            tx_q <= 1'b0;
          end
        end

        StMark: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end

        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a bit-queue reference model of the serial line checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_cfg;

  localparam int unsigned W  = 8;
  localparam int unsigned DB = 16;

  localparam int MIdle  = 0;
  localparam int MFrame = 1;
  localparam int MBreak = 2;

  logic          clk;
  logic          rst;
  logic          cts;
  logic [DB-1:0] div;
  logic [1:0]    parity;
  logic          stop2;
  logic          brk;
  logic          tx;
  logic          busy;

  uart_tx_cfg_if #(.WIDTH(W)) fifo_if ();

  uart_tx_cfg #(
    .WIDTH   (W),
    .DIV_BITS(DB)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .fifo    (fifo_if),
    .cts_i   (cts),
    .div_i   (div),
    .parity_i(parity),
    .stop2_i (stop2),
    .brk_i   (brk),
    .tx_o    (tx),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic         q_tx[$];
  logic [W-1:0] fifo_q[$];
  int           mode;
  int           bcnt;
  int           mdiv;
  logic         m_c1;
  logic         m_c2;
  logic         exp_tx;

  // Bookkeeping.
  int   n_chk;
  int   n_fail;
  int   cyc;
  bit   chk_en;
  int   win_busy;
  int   win_gets;
  logic txq[$];
  int   get_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    fifo_if.empty = (fifo_q.size() == 0);
    fifo_if.in    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // Expand one word into per-clock line levels under the current configuration.
  task automatic build_frame(input logic [W-1:0] d);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    case (parity)
      2'b01:   bits.push_back(^d);
      2'b10:   bits.push_back(~^d);
      2'b11:   bits.push_back(1'b1);
      default: ;
    endcase
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k <= int'(div); k++) q_tx.push_back(bits[i]);
    end
  endtask

  // Advance the model across one rising edge, using the inputs present at that edge.
  task automatic model_step();
    logic cs;
    cs   = m_c2;
    m_c2 = m_c1;
    m_c1 = cts;
    if (rst) begin
      q_tx.delete();
      mode   = MIdle;
      exp_tx = 1'b1;
    end else begin
      case (mode)
        MIdle: begin
          if (brk) begin
            mode   = MBreak;
            bcnt   = 1;
            mdiv   = int'(div);
            exp_tx = 1'b0;
          end else if (!cs && fifo_q.size() > 0) begin
            build_frame(fifo_q.pop_front());
            mode   = MFrame;
            exp_tx = q_tx.pop_front();
          end else begin
            exp_tx = 1'b1;
          end
        end
        MFrame: begin
          if (q_tx.size() > 0) begin
            exp_tx = q_tx.pop_front();
          end else begin
            mode   = MIdle;
            exp_tx = 1'b1;
          end
        end
        default: begin
          if (bcnt >= mdiv + 1 && !brk) begin
            for (int k = 0; k <= mdiv; k++) q_tx.push_back(1'b1);
            mode   = MFrame;
            exp_tx = q_tx.pop_front();
          end else begin
            bcnt++;
            exp_tx = 1'b0;
          end
        end
      endcase
    end
  endtask

  task automatic compare();
    logic exp_get;
    exp_get = !rst && (mode == MIdle) && !brk && !m_c2 && (fifo_q.size() > 0);
    check("tx", tx, exp_tx);
    check("busy", busy, mode != MIdle);
    check("get", fifo_if.get, exp_get);
    if (busy === 1'b1) begin
      win_busy++;
      txq.push_back(tx);
    end
    if (fifo_if.get === 1'b1) begin
      win_gets++;
      get_cyc.push_back(cyc);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_fifo();
    #1;
    if (chk_en) compare();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic win_clear();
    win_busy = 0;
    win_gets = 0;
    txq.delete();
    get_cyc.delete();
  endtask

  task automatic cfg(input int d, input logic [1:0] p, input logic s2);
    div    = DB'(d);
    parity = p;
    stop2  = s2;
  endtask

  initial begin
    logic [9:0] pat;
    int         lat;
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    cts    = 1'b0;
    brk    = 1'b0;
    cfg(3, 2'b00, 1'b0);
    m_c1   = 1'b0;
    m_c2   = 1'b0;
    mode   = MIdle;
    bcnt   = 0;
    mdiv   = 0;
    exp_tx = 1'b1;
    drive_fifo();
    win_clear();
    run(4);
    chk_en = 1'b1;
    run(2);
    rst = 1'b0;
    run(3);

    // 8N1 frame of A5 at div=3.
    fifo_q.push_back(8'hA5);
    win_clear();
    run(60);
    check("t1_busy_clocks", win_busy, 40);
    check("t1_gets", win_gets, 1);
    for (int i = 0; i < 10; i++) pat[i] = (txq.size() > 4 * i) ? txq[4 * i] : 1'bx;
    check("t1_pattern", pat, 10'b1101001010);

    // Parity variants and two stop bits.
    cfg(3, 2'b01, 1'b0);
    fifo_q.push_back(8'hA5);
    win_clear();
    run(60);
    check("t2_even_busy", win_busy, 44);
    check("t2_even_bit", (txq.size() > 36) ? txq[36] : 1'bx, 0);
    cfg(3, 2'b10, 1'b0);
    fifo_q.push_back(8'hA5);
    win_clear();
    run(60);
    check("t2_odd_bit", (txq.size() > 36) ? txq[36] : 1'bx, 1);
    cfg(3, 2'b11, 1'b1);
    fifo_q.push_back(8'hA5);
    win_clear();
    run(60);
    check("t2_mark_bit", (txq.size() > 36) ? txq[36] : 1'bx, 1);
    check("t2_stop2_busy", win_busy, 48);

    // Back-to-back at div=0.
    cfg(0, 2'b00, 1'b0);
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    win_clear();
    run(30);
    check("t3_gets", win_gets, 2);
    check("t3_busy", win_busy, 20);
    check("t3_get_gap", (get_cyc.size() == 2) ? get_cyc[1] - get_cyc[0] : -1, 11);

    // CTS gating.
    cfg(3, 2'b00, 1'b0);
    cts = 1'b1;
    run(3);
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h96);
    win_clear();
    run(10);
    check("t4_blocked_gets", win_gets, 0);
    check("t4_blocked_tx", tx, 1);
    cts = 1'b0;
    lat = 0;
    while (win_gets == 0 && lat < 8) begin
      cycle();
      lat++;
    end
    check("t4_release_latency_ok", lat <= 3, 1);
    run(5);
    cts = 1'b1;
    run(60);
    check("t4_single_get", win_gets, 1);
    check("t4_frame_unchanged", win_busy, 40);
    cts = 1'b0;
    run(60);

    // Break while a frame is in flight.
    cfg(1, 2'b00, 1'b0);
    fifo_q.push_back(8'h81);
    win_clear();
    run(5);
    brk = 1'b1;
    fifo_q.push_back(8'h7E);
    run(40);
    check("t5_gets_during_brk", win_gets, 1);
    check("t5_brk_tx_low", tx, 0);
    check("t5_brk_busy", busy, 1);
    brk = 1'b0;
    run(40);
    check("t5_gets_after", win_gets, 2);

    // Reset mid-frame at data bit 3.
    cfg(3, 2'b00, 1'b0);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hC3);
    win_clear();
    lat = 0;
    while (win_gets == 0 && lat < 10) begin
      cycle();
      lat++;
    end
    check("t6_first_get_seen", win_gets, 1);
    run(16);
    rst = 1'b1;
    cycle();
    check("t6_rst_tx", tx, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_get", fifo_if.get, 0);
    rst = 1'b0;
    win_clear();
    run(60);
    check("t6_after_gets", win_gets, 1);
    check("t6_after_busy", win_busy, 40);
    win_clear();
    run(50);
    check("t6_empty_gets", win_gets, 0);
    check("t6_empty_busy", win_busy, 0);
    check("t6_empty_tx", tx, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (fifo_q.size() < 3 && $urandom_range(0, 7) == 0) fifo_q.push_back(W'($urandom));
      if ($urandom_range(0, 49) == 0) cts = ~cts;
      if ($urandom_range(0, 79) == 0) brk = ~brk;
      if ($urandom_range(0, 19) == 0) begin
        cfg(int'($urandom_range(0, 3)), 2'($urandom), 1'($urandom));
      end
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;
    cts = 1'b0;
    brk = 1'b0;
    run(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
